// File: rtl/m92_clk_pkg.sv
// Shared sequencer state encoding and default clock-enable ratios for the M92 core.
package m92_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_LOCK_STABLE = 1024;
    localparam int unsigned DEF_RST_HOLD    = 256;
    localparam int unsigned DEF_CPU_NUM     = 27;
    localparam int unsigned DEF_CPU_DEN     = 320;
    localparam int unsigned DEF_SND_NUM     = 179;
    localparam int unsigned DEF_SND_DEN     = 5334;
    localparam int unsigned DEF_PIX_DIV     = 16;
    localparam int unsigned DEF_ACC_W       = 16;

    // Width of a counter able to hold the larger of two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/m92_clk_rst_seq_frac_ce_gen.sv
// Fractional clock-enable generator: emits NUM single-cycle pulses per DEN clocks while run is high.
module frac_ce_gen
    import m92_clk_pkg::*;
#(
    parameter int unsigned NUM = DEF_CPU_NUM,
    parameter int unsigned DEN = DEF_CPU_DEN,
    parameter int unsigned W   = DEF_ACC_W
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic run,
    output logic ce
);

    logic [W-1:0] acc_q, acc_d;
    logic         ce_q, ce_d;
    logic [W:0]   sum;

    // One extra bit keeps acc+NUM from wrapping before the compare.
    always_comb begin
        sum   = {1'b0, acc_q} + (W+1)'(NUM);
        acc_d = '0;
        ce_d  = 1'b0;
        if (run) begin
            if (sum >= (W+1)'(DEN)) begin
                acc_d = W'(sum - (W+1)'(DEN));
                ce_d  = 1'b1;
            end else begin
                acc_d = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/m92_clk_rst_seq.sv
// PLL lock qualification, core reset sequencing and CPU/sound/pixel clock-enable generation.
module m92_clk_rst_seq
    import m92_clk_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int unsigned RST_HOLD    = DEF_RST_HOLD,
    parameter int unsigned CPU_NUM     = DEF_CPU_NUM,
    parameter int unsigned CPU_DEN     = DEF_CPU_DEN,
    parameter int unsigned SND_NUM     = DEF_SND_NUM,
    parameter int unsigned SND_DEN     = DEF_SND_DEN,
    parameter int unsigned PIX_DIV     = DEF_PIX_DIV,
    parameter int unsigned ACC_W       = DEF_ACC_W
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    input  logic       pause,
    output logic       core_reset,
    output logic       ce_cpu,
    output logic       ce_snd,
    output logic       ce_pix,
    output logic [1:0] seq_state
);

    localparam int unsigned CNT_W = cnt_width(LOCK_STABLE, RST_HOLD);
    localparam int unsigned PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic             lk_meta_q, lk_s_q;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_reset_q;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             ce_pix_q;
    logic             gen_run;
    logic             ce_cpu_raw;

    // Loss of lock outranks soft_reset in every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s_q) state_d = STABLE;
            end
            STABLE: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lk_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (soft_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk_s_q)        state_d = WAIT_LOCK;
                else if (soft_reset) state_d = HOLD;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign gen_run = (state_q == HOLD) || (state_q == RUN);

    always_comb begin
        pix_cnt_d = '0;
        if (gen_run) begin
            pix_cnt_d = (pix_cnt_q == PIX_W'(PIX_DIV - 1)) ? '0 : pix_cnt_q + PIX_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            pix_cnt_q    <= '0;
            ce_pix_q     <= 1'b0;
        end else begin
            lk_meta_q    <= pll_locked;
            lk_s_q       <= lk_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= (state_d != RUN);
            pix_cnt_q    <= pix_cnt_d;
            // Registered so ce_pix is high exactly while the counter holds PIX_DIV-1.
            ce_pix_q     <= gen_run && (pix_cnt_d == PIX_W'(PIX_DIV - 1));
        end
    end

    frac_ce_gen #(.NUM(CPU_NUM), .DEN(CPU_DEN), .W(ACC_W)) u_ce_cpu (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .run     (gen_run),
        .ce      (ce_cpu_raw)
    );

    frac_ce_gen #(.NUM(SND_NUM), .DEN(SND_DEN), .W(ACC_W)) u_ce_snd (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .run     (gen_run),
        .ce      (ce_snd)
    );

    // pause only hides CPU pulses; the accumulator keeps its phase.
    assign ce_cpu     = ce_cpu_raw & ~pause;
    assign ce_pix     = ce_pix_q;
    assign core_reset = core_reset_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_m92_clk_rst_seq.sv
// Scoreboard bench for m92_clk_rst_seq: stimulus queues expectations, a monitor pops them on DUT events.
module tb_m92_clk_rst_seq;

    logic       clk_sys    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pause      = 1'b0;
    logic       core_reset, ce_cpu, ce_snd, ce_pix;
    logic [1:0] seq_state;

    always #5 clk_sys = ~clk_sys;

    m92_clk_rst_seq dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .soft_reset (soft_reset),
        .pause      (pause),
        .core_reset (core_reset),
        .ce_cpu     (ce_cpu),
        .ce_snd     (ce_snd),
        .ce_pix     (ce_pix),
        .seq_state  (seq_state)
    );

    typedef struct {
        string name;
        int    cpu_lo, cpu_hi, snd_lo, snd_hi, pix_lo, pix_hi;
    } win_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   q_state[$], q_fall[$], q_rise[$], q_fcpu[$], q_fsnd[$], q_fpix[$];
    win_t q_win[$];
    bit   win        = 1'b0;
    int   phase_mode = 0;
    bit [319:0] phase_set = '0;
    int   phase_err  = 0;

    function automatic void chk(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // Monitor: samples 1 time unit after each rising edge; cyc = number of edges seen.
    initial begin
        int wc, ws, wp, wadj, prev_st;
        bit prev_cpu, win_prev, prev_cr;
        wc = 0; ws = 0; wp = 0; wadj = 0; prev_st = 0;
        prev_cpu = 1'b0; win_prev = 1'b0; prev_cr = 1'b1;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (int'(seq_state) != prev_st) begin
                if (q_state.size() == 0) chk("state_unexpected", int'(seq_state), -1, -1);
                else begin
                    automatic int e;
                    e = q_state.pop_front();
                    chk("state_seq", int'(seq_state), e, e);
                end
                prev_st = int'(seq_state);
            end
            if (prev_cr && !core_reset) begin
                if (q_fall.size() == 0) chk("core_reset_fall_unexpected", cyc, -1, -1);
                else begin
                    automatic int e;
                    e = q_fall.pop_front();
                    chk("core_reset_fall_cycle", cyc, e, e);
                end
            end
            if (!prev_cr && core_reset) begin
                if (q_rise.size() == 0) chk("core_reset_rise_unexpected", cyc, -1, -1);
                else begin
                    automatic int e;
                    e = q_rise.pop_front();
                    chk("core_reset_rise_cycle", cyc, e, e);
                end
            end
            prev_cr = core_reset;
            if (ce_cpu && q_fcpu.size() != 0) begin
                automatic int e;
                e = q_fcpu.pop_front();
                chk("first_ce_cpu_cycle", cyc, e, e);
            end
            if (ce_snd && q_fsnd.size() != 0) begin
                automatic int e;
                e = q_fsnd.pop_front();
                chk("first_ce_snd_cycle", cyc, e, e);
            end
            if (ce_pix && q_fpix.size() != 0) begin
                automatic int e;
                e = q_fpix.pop_front();
                chk("first_ce_pix_cycle", cyc, e, e);
            end
            if (phase_mode == 1 && ce_cpu) phase_set[cyc % 320] = 1'b1;
            if (phase_mode == 2 && ce_cpu && !phase_set[cyc % 320]) phase_err++;
            if (win) begin
                wc += int'(ce_cpu);
                ws += int'(ce_snd);
                wp += int'(ce_pix);
                if (ce_cpu && prev_cpu) wadj++;
            end
            if (win_prev && !win) begin
                if (q_win.size() == 0) chk("window_unexpected", wc, -1, -1);
                else begin
                    automatic win_t w;
                    w = q_win.pop_front();
                    chk({w.name, "_ce_cpu_count"}, wc, w.cpu_lo, w.cpu_hi);
                    chk({w.name, "_ce_snd_count"}, ws, w.snd_lo, w.snd_hi);
                    chk({w.name, "_ce_pix_count"}, wp, w.pix_lo, w.pix_hi);
                    chk({w.name, "_ce_cpu_adjacent"}, wadj, 0, 0);
                end
                wc = 0; ws = 0; wp = 0; wadj = 0;
            end
            win_prev = win;
            prev_cpu = ce_cpu;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic run_win(input string nm, input int n, input int clo, input int chi,
                           input int slo, input int shi, input int plo, input int phi);
        win_t w;
        w.name = nm; w.cpu_lo = clo; w.cpu_hi = chi;
        w.snd_lo = slo; w.snd_hi = shi; w.pix_lo = plo; w.pix_hi = phi;
        q_win.push_back(w);
        win = 1'b1;
        tick(n);
        win = 1'b0;
        tick(2);
    endtask

    task automatic drain(input string nm, input int budget);
        int k, pend;
        k = 0;
        pend = q_state.size() + q_fall.size() + q_rise.size() + q_fcpu.size()
             + q_fsnd.size() + q_fpix.size() + q_win.size();
        while (pend != 0 && k < budget) begin
            tick(1);
            k++;
            pend = q_state.size() + q_fall.size() + q_rise.size() + q_fcpu.size()
                 + q_fsnd.size() + q_fpix.size() + q_win.size();
        end
        chk({nm, "_pending_expectations"}, pend, 0, 0);
    endtask

    // Expectations relative to the edge count c at which pll_locked (as seen by the sync) rises:
    // STABLE at c+3, HOLD at c+1027, RUN/core_reset fall at c+1283.
    // First pulses after HOLD entry with zeroed state: cpu 27*12>=320 -> +12, snd 179*30>=5334 -> +30, pix +15.
    task automatic push_lock_expect(input int c);
        q_fall.push_back(c + 1283);
        q_fcpu.push_back(c + 1027 + 12);
        q_fsnd.push_back(c + 1027 + 30);
        q_fpix.push_back(c + 1027 + 15);
    endtask

    initial begin
        int c0, s0, l0, r;
        tick(3);
        chk("reset_core_reset", int'(core_reset), 1, 1);
        chk("reset_ce_cpu", int'(ce_cpu), 0, 0);
        chk("reset_ce_snd", int'(ce_snd), 0, 0);
        chk("reset_ce_pix", int'(ce_pix), 0, 0);
        chk("reset_seq_state", int'(seq_state), 0, 0);
        reset_n = 1'b1;
        tick(9);

        // Clean bring-up.
        c0 = cyc;
        q_state.push_back(1); q_state.push_back(2); q_state.push_back(3);
        push_lock_expect(c0);
        pll_locked = 1'b1;
        drain("bringup", 1400);

        // Long-run ratios.
        run_win("ratio", 32000, 2699, 2701, 1073, 1075, 1999, 2001);

        // Pause: learn CPU pulse phase, mask, then confirm phase is unchanged.
        phase_mode = 1;
        run_win("pre_pause", 320, 27, 27, 10, 11, 20, 20);
        phase_mode = 0;
        pause = 1'b1;
        run_win("pause", 1000, 0, 0, 33, 34, 62, 63);
        pause = 1'b0;
        phase_mode = 2;
        run_win("post_pause", 320, 27, 27, 10, 11, 20, 20);
        phase_mode = 0;
        chk("cpu_phase_after_pause", phase_err, 0, 0);

        // soft_reset for 5 cycles in RUN: HOLD at s0+1, RUN again 256 edges after the last soft edge.
        s0 = cyc;
        q_rise.push_back(s0 + 1);
        q_fall.push_back(s0 + 261);
        q_state.push_back(2); q_state.push_back(3);
        begin
            win_t w;
            w.name = "soft"; w.cpu_lo = 27; w.cpu_hi = 27;
            w.snd_lo = 10; w.snd_hi = 11; w.pix_lo = 20; w.pix_hi = 20;
            q_win.push_back(w);
        end
        win = 1'b1;
        soft_reset = 1'b1;
        tick(5);
        soft_reset = 1'b0;
        tick(315);
        win = 1'b0;
        tick(2);
        drain("soft", 100);

        // Lock loss in RUN: core_reset at l0+3, enables silent from l0+4.
        l0 = cyc;
        q_rise.push_back(l0 + 3);
        q_state.push_back(0);
        pll_locked = 1'b0;
        tick(3);
        run_win("lost", 40, 0, 0, 0, 0, 0, 0);
        drain("lost", 50);

        // Re-lock with a 3-cycle glitch at stable count 500.
        q_state.push_back(1);
        pll_locked = 1'b1;
        tick(503);
        q_state.push_back(0); q_state.push_back(1); q_state.push_back(2); q_state.push_back(3);
        pll_locked = 1'b0;
        tick(3);
        r = cyc;
        push_lock_expect(r);
        pll_locked = 1'b1;
        drain("relock", 1400);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
